// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the control unit and the divider.
// DIV_UNSIGNED_EN adds the div_unsigned select sampled alongside start.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] lo_out;
  logic [WIDTH-1:0] hi_out;
  logic             busy;
  logic             done;
  logic             div0;
`ifdef DIV_UNSIGNED_EN
  logic             div_unsigned;

  modport master (
    output start, a_in, b_in, div_unsigned,
    input  lo_out, hi_out, busy, done, div0
  );

  modport slave (
    input  start, a_in, b_in, div_unsigned,
    output lo_out, hi_out, busy, done, div0
  );
`else
  modport master (
    output start, a_in, b_in,
    input  lo_out, hi_out, busy, done, div0
  );

  modport slave (
    input  start, a_in, b_in,
    output lo_out, hi_out, busy, done, div0
  );
`endif
endinterface

// File: rtl/div_unit.sv
// Multicycle restoring divider, one quotient bit per cycle; signed by default.
// Defining DIV_UNSIGNED_EN adds a per-operation unsigned mode (DIVU).
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clock,
  input  logic      reset,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [CW-1:0]    cnt_q;
  logic             signQuo_q;
  logic             signRem_q;
  logic             busy_q;
  logic             done_q;
  logic             div0_q;

  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic             unsignedOp;

`ifdef DIV_UNSIGNED_EN
  assign unsignedOp = bus.div_unsigned;
`else
  assign unsignedOp = 1'b0;
`endif

  // Unsigned magnitudes; the most negative value maps onto itself, which is the correct magnitude.
  assign absA = (!unsignedOp && bus.a_in[WIDTH-1]) ? -bus.a_in : bus.a_in;
  assign absB = (!unsignedOp && bus.b_in[WIDTH-1]) ? -bus.b_in : bus.b_in;

  // One restoring step: the extra compare bit catches a shifted remainder that overflows WIDTH.
  always_comb begin
    remShift = {rem_q, quo_q[WIDTH-1]};
    if (remShift >= {1'b0, div_q}) begin
      rem_d = WIDTH'(remShift - {1'b0, div_q});
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = remShift[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      quo_q     <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      signQuo_q <= 1'b0;
      signRem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.b_in == '0) begin
              state_q <= ZERO;
            end else begin
              quo_q     <= absA;
              div_q     <= absB;
              rem_q     <= '0;
              signQuo_q <= !unsignedOp && (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
              signRem_q <= !unsignedOp && bus.a_in[WIDTH-1];
              div0_q    <= 1'b0;
              cnt_q     <= CW'(WIDTH);
              state_q   <= RUN;
            end
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q <= FIX;
          end
        end
        FIX: begin
          lo_q    <= signQuo_q ? -quo_q : quo_q;
          hi_q    <= signRem_q ? -rem_q : rem_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        ZERO: begin
          done_q  <= 1'b1;
          div0_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.lo_out = lo_q;
  assign bus.hi_out = hi_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.div0   = div0_q;
endmodule
